// File: rtl/sigma_delta_modulator.sv
// First-order error-feedback delta-sigma modulator with a 2-entry sample FIFO.
// Linearly interpolates between consecutive PCM samples across each OSR-cycle frame.
module sigma_delta_modulator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OSR   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             OUT,
    output logic             UNDERRUN
);

    localparam int unsigned L  = $clog2(OSR);
    localparam int unsigned AW = WIDTH + L;
    localparam logic [WIDTH-1:0] MID    = WIDTH'(1 << (WIDTH - 1));
    localparam logic [L-1:0]     K_LAST = L'(OSR - 1);

    logic [L-1:0]            k_q, k_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [1:0][WIDTH-1:0]   fifo_q, fifo_d;
    logic [WIDTH-1:0]        prev_q, prev_d;
    logic [WIDTH-1:0]        cur_q, cur_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic                    out_q, out_d;
    logic                    underrun_q, underrun_d;
    logic                    in_ready_q, in_ready_d;

    logic                    push_c;
    logic                    boundary_c;
    logic                    pop_c;
    logic [AW-1:0]           v_c;
    logic [AW:0]             sum_c;

    // Next-state: FIFO (pop before push), frame bookkeeping, interpolation, modulator
    always_comb begin
        push_c     = IN_VALID && in_ready_q;
        boundary_c = (k_q == K_LAST);
        pop_c      = boundary_c && (cnt_q != 2'd0);

        k_d        = k_q + L'(1);
        fifo_d     = fifo_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        cur_d      = cur_q;

        if (boundary_c) begin
            prev_d = cur_q;
        end
        if (pop_c) begin
            cur_d     = fifo_q[0];
            fifo_d[0] = fifo_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        if (push_c) begin
            fifo_d[cnt_d[0]] = IN;
            cnt_d            = cnt_d + 2'd1;
        end

        in_ready_d = (cnt_d < 2'd2);
        underrun_d = boundary_c && (cnt_q == 2'd0);

        // prev*(OSR-k) + cur*k equals prev*OSR + (cur-prev)*k and stays unsigned
        v_c   = AW'(prev_q) * (AW'(OSR) - AW'(k_q)) + AW'(cur_q) * AW'(k_q);
        sum_c = {1'b0, acc_q} + {1'b0, v_c};
        acc_d = sum_c[AW-1:0];
        out_d = sum_c[AW];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            k_q        <= '0;
            cnt_q      <= '0;
            fifo_q     <= '0;
            prev_q     <= MID;
            cur_q      <= MID;
            acc_q      <= '0;
            out_q      <= 1'b0;
            underrun_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            fifo_q     <= fifo_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            underrun_q <= underrun_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign IN_READY = in_ready_q;
    assign OUT      = out_q;
    assign UNDERRUN = underrun_q;

endmodule
